// File: rtl/multi_ball_engine.sv
`default_nettype none
// ============================================================================
// multi_ball_engine : time-multiplexed gravity/paddle/wall update of N balls
// Revision 1.0
// ============================================================================
module multi_ball_engine #(
  parameter int N_BALLS = 4,
  parameter int POS_W   = 9,
  parameter int VEL_W   = 10,
  parameter int Y_MAX   = 310,
  parameter int G       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [N_BALLS-1:0]         release_req,  // 'release' is a reserved word
  input  logic [POS_W-1:0]           home,
  input  logic [POS_W-1:0]           handline,
  input  logic [7:0]                 hand_velocity,
  input  logic [1:0]                 k,
  output logic [N_BALLS*POS_W-1:0]   ball_y,
  output logic [N_BALLS-1:0]         active,
  output logic [N_BALLS-1:0]         lost,
  output logic [N_BALLS-1:0]         bounce_pulse,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int CW    = 32;
  localparam int V_LIM = (1 << (VEL_W - 1)) - 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [POS_W-1:0]        y_q [N_BALLS];
  logic [POS_W-1:0]        y_d [N_BALLS];
  logic signed [VEL_W-1:0] v_q [N_BALLS];
  logic signed [VEL_W-1:0] v_d [N_BALLS];
  logic [N_BALLS-1:0]      active_q, active_d, lost_q, lost_d;
  logic [N_BALLS-1:0]      pending_q, pending_d, bounce_q, bounce_d, overrun_q, consume;
  logic [POS_W-1:0]        cur_y_q, cur_y_d;
  logic signed [VEL_W-1:0] cur_v_q, cur_v_d;
  logic                    cur_act_q, cur_act_d, cur_lost_q, cur_lost_d;
  logic                    cur_bnc_q, cur_bnc_d, launch_q, launch_d;
  logic                    overrun_d;
  logic signed [CW-1:0]    v1, yn, y_ext, hl_ext, kick, bnc_v;

  function automatic logic signed [CW-1:0] sat(input logic signed [CW-1:0] x);
    if (x > V_LIM) return V_LIM;
    if (x < -V_LIM) return -V_LIM;
    return x;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a tick in DONE starts the next frame directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_LOAD;
      S_LOAD:  state_d = S_CALC;
      S_CALC:  state_d = S_WRITE;
      S_WRITE: state_d = (idx_q == IDX_W'(N_BALLS - 1)) ? S_DONE : S_LOAD;
      S_DONE:  state_d = tick ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_WRITE);
    done = (state_q == S_DONE);
  end

  // Physics of the ball currently held in the working registers
  always_comb begin
    y_ext  = $signed(CW'(cur_y_q));
    hl_ext = $signed(CW'(handline));
    v1     = sat(CW'(cur_v_q) + G);
    yn     = y_ext + v1;
    kick   = (v1 * ($signed(CW'(k)) + 1)) >>> 2;
    bnc_v  = sat(-kick - $signed(CW'(hand_velocity)));
  end

  always_comb begin
    idx_d      = idx_q;
    y_d        = y_q;
    v_d        = v_q;
    active_d   = active_q;
    lost_d     = lost_q;
    bounce_d   = '0;
    consume    = '0;
    cur_y_d    = cur_y_q;
    cur_v_d    = cur_v_q;
    cur_act_d  = cur_act_q;
    cur_lost_d = cur_lost_q;
    cur_bnc_d  = cur_bnc_q;
    launch_d   = launch_q;
    case (state_q)
      S_IDLE, S_DONE: idx_d = '0;
      S_LOAD: begin
        cur_y_d    = y_q[idx_q];
        cur_v_d    = v_q[idx_q];
        cur_act_d  = active_q[idx_q];
        cur_lost_d = lost_q[idx_q];
        cur_bnc_d  = 1'b0;
        launch_d   = pending_q[idx_q];
        if (pending_q[idx_q]) begin
          consume[idx_q] = 1'b1;
          cur_y_d    = (CW'(home) >= Y_MAX) ? POS_W'(Y_MAX - 1) : home;
          cur_v_d    = '0;
          cur_act_d  = 1'b1;
          cur_lost_d = 1'b0;
        end
      end
      S_CALC: begin
        if (cur_act_q && !launch_q) begin
          if (yn >= Y_MAX) begin
            cur_y_d    = POS_W'(Y_MAX);
            cur_v_d    = '0;
            cur_act_d  = 1'b0;
            cur_lost_d = 1'b1;
          end else if (v1 > 0 && y_ext < hl_ext && yn >= hl_ext) begin
            cur_y_d   = handline;
            cur_v_d   = VEL_W'(bnc_v);
            cur_bnc_d = 1'b1;
          end else if (yn < 0) begin
            cur_y_d = '0;
            cur_v_d = VEL_W'(-v1);
          end else begin
            cur_y_d = POS_W'(yn);
            cur_v_d = VEL_W'(v1);
          end
        end
      end
      S_WRITE: begin
        y_d[idx_q]      = cur_y_q;
        v_d[idx_q]      = cur_v_q;
        active_d[idx_q] = cur_act_q;
        lost_d[idx_q]   = cur_lost_q;
        bounce_d[idx_q] = cur_bnc_q;
        idx_d           = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // A release coinciding with its own consume survives into the next frame
  always_comb begin
    pending_d = (pending_q & ~consume) | release_req;
    overrun_d = overrun_q[0] | (tick & busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BALLS; i++) begin
        y_q[i] <= '0;
        v_q[i] <= '0;
      end
      idx_q      <= '0;
      active_q   <= '0;
      lost_q     <= '0;
      pending_q  <= '0;
      bounce_q   <= '0;
      overrun_q  <= '0;
      cur_y_q    <= '0;
      cur_v_q    <= '0;
      cur_act_q  <= 1'b0;
      cur_lost_q <= 1'b0;
      cur_bnc_q  <= 1'b0;
      launch_q   <= 1'b0;
    end else begin
      y_q        <= y_d;
      v_q        <= v_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      lost_q     <= lost_d;
      pending_q  <= pending_d;
      bounce_q   <= bounce_d;
      overrun_q  <= {{(N_BALLS-1){1'b0}}, overrun_d};
      cur_y_q    <= cur_y_d;
      cur_v_q    <= cur_v_d;
      cur_act_q  <= cur_act_d;
      cur_lost_q <= cur_lost_d;
      cur_bnc_q  <= cur_bnc_d;
      launch_q   <= launch_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_out
      assign ball_y[gi*POS_W +: POS_W] = y_q[gi];
    end
  endgenerate

  assign active       = active_q;
  assign lost         = lost_q;
  assign bounce_pulse = bounce_q;
  assign overrun      = overrun_q[0];

endmodule
`default_nettype wire
